traffic_phase_scheduler: RTL and testbench

//  Sequences a two-direction (NS/EW) traffic-light intersection through fixed-duration phases.

---
 rtl/traffic_phase_scheduler.sv | 147 ++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler.sv
// Two-direction traffic-light phase sequencer: fixed-duration phases, manual
// advance, pause, and a flashing-yellow night mode entered only from all-red.
module traffic_phase_scheduler #(
    parameter int TICKS_PER_SEC = 10000,
    parameter int T_GREEN       = 25,
    parameter int T_YELLOW      = 3,
    parameter int T_ALLRED      = 2,
    parameter int FLASH_TICKS   = 5000
) (
    input  logic       Sys_CLK,
    input  logic       Sys_RST,
    input  logic       tick_en,
    input  logic       key_next,
    input  logic       pause,
    input  logic       night_mode,
    output logic [2:0] state,
    output logic [6:0] count,
    output logic [3:0] LED,
    output logic       phase_change
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int FW = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;

    typedef enum logic [2:0] {
        S_ALLRED_A  = 3'd0,
        S_NS_GREEN  = 3'd1,
        S_NS_YELLOW = 3'd2,
        S_ALLRED_B  = 3'd3,
        S_EW_GREEN  = 3'd4,
        S_EW_YELLOW = 3'd5,
        S_NIGHT     = 3'd6,
        S_ILLEGAL   = 3'd7
    } phase_t;

    phase_t          r_state;
    logic [6:0]      r_count;
    logic [PW-1:0]   r_presc;
    logic            r_flash;
    logic [FW-1:0]   r_fcnt;
    logic            r_pc;

    logic            w_run;
    logic            w_sec;
    logic            w_key;
    logic            w_adv;
    phase_t          w_next;

    function automatic logic [6:0] f_load(input phase_t p);
        case (p)
            S_NS_GREEN, S_EW_GREEN:   f_load = 7'(T_GREEN);
            S_NS_YELLOW, S_EW_YELLOW: f_load = 7'(T_YELLOW);
            S_NIGHT:                  f_load = 7'd0;
            default:                  f_load = 7'(T_ALLRED);
        endcase
    endfunction

    assign w_run = tick_en && !pause;
    assign w_sec = w_run && (r_presc == PW'(TICKS_PER_SEC - 1));
    assign w_key = key_next && !pause &&
                   (r_state inside {S_ALLRED_A, S_NS_GREEN, S_ALLRED_B, S_EW_GREEN});
    // A key on the same cycle as an expiring second still advances only once.
    assign w_adv = w_key || (w_sec && (r_count == 7'd1));

    // Night mode is only honoured when leaving an all-red phase.
    always_comb begin
        w_next = S_ALLRED_A;
        case (r_state)
            S_ALLRED_A:  w_next = night_mode ? S_NIGHT : S_NS_GREEN;
            S_NS_GREEN:  w_next = S_NS_YELLOW;
            S_NS_YELLOW: w_next = S_ALLRED_B;
            S_ALLRED_B:  w_next = night_mode ? S_NIGHT : S_EW_GREEN;
            S_EW_GREEN:  w_next = S_EW_YELLOW;
            default:     w_next = S_ALLRED_A;
        endcase
    end

    always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
        if (!Sys_RST) begin
            r_state <= S_ALLRED_A;
            r_count <= 7'(T_ALLRED);
            r_presc <= '0;
            r_flash <= 1'b0;
            r_fcnt  <= '0;
            r_pc    <= 1'b0;
        end else begin
            r_pc <= 1'b0;
            case (r_state)
                S_ILLEGAL: begin
                    r_state <= S_ALLRED_A;
                    r_count <= 7'(T_ALLRED);
                    r_presc <= '0;
                    r_flash <= 1'b0;
                    r_fcnt  <= '0;
                    r_pc    <= 1'b1;
                end
                S_NIGHT: begin
                    if (!night_mode) begin
                        r_state <= S_ALLRED_A;
                        r_count <= 7'(T_ALLRED);
                        r_presc <= '0;
                        r_flash <= 1'b0;
                        r_fcnt  <= '0;
                        r_pc    <= 1'b1;
                    end else if (w_run) begin
                        if (r_fcnt == FW'(FLASH_TICKS - 1)) begin
                            r_fcnt  <= '0;
                            r_flash <= ~r_flash;
                        end else begin
                            r_fcnt <= r_fcnt + 1'b1;
                        end
                    end
                end
                default: begin
                    if (w_adv) begin
                        r_state <= w_next;
                        r_count <= f_load(w_next);
                        r_presc <= '0;
                        r_pc    <= 1'b1;
                        r_fcnt  <= '0;
                        r_flash <= (w_next == S_NIGHT);
                    end else if (w_run) begin
                        r_presc <= w_sec ? '0 : r_presc + 1'b1;
                        if (w_sec) r_count <= r_count - 7'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        LED = 4'b0000;
        case (r_state)
            S_NS_GREEN:  LED = 4'b0001;
            S_NS_YELLOW: LED = 4'b0010;
            S_EW_GREEN:  LED = 4'b0100;
            S_EW_YELLOW: LED = 4'b1000;
            S_NIGHT:     LED = {r_flash, 1'b0, r_flash, 1'b0};
            default:     LED = 4'b0000;
        endcase
    end

    assign state        = r_state;
    assign count        = r_count;
    assign phase_change = r_pc;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench for traffic_phase_scheduler: a behavioural model pushes the
// expected {state,count,LED,phase_change} each cycle; tests pop and compare.
module tb_traffic_phase_scheduler;

    localparam int TPS = 4;
    localparam int TG  = 3;
    localparam int TY  = 2;
    localparam int TAR = 1;
    localparam int FL  = 2;

    logic       Sys_CLK;
    logic       Sys_RST;
    logic       tick_en;
    logic       key_next;
    logic       pause;
    logic       night_mode;
    logic [2:0] state;
    logic [6:0] count;
    logic [3:0] LED;
    logic       phase_change;

    traffic_phase_scheduler #(
        .TICKS_PER_SEC(TPS), .T_GREEN(TG), .T_YELLOW(TY),
        .T_ALLRED(TAR), .FLASH_TICKS(FL)
    ) dut (
        .Sys_CLK(Sys_CLK), .Sys_RST(Sys_RST), .tick_en(tick_en),
        .key_next(key_next), .pause(pause), .night_mode(night_mode),
        .state(state), .count(count), .LED(LED), .phase_change(phase_change)
    );

    initial Sys_CLK = 1'b0;
    always #5 Sys_CLK = ~Sys_CLK;

    int checks = 0;
    int errors = 0;

    logic [14:0] w_act;
    assign w_act = {state, count, LED, phase_change};

    logic [14:0] sb[$];
    logic [14:0] e;

    // reference model state
    logic [2:0] m_s;
    int         m_c;
    int         m_p;
    logic       m_f;
    int         m_fc;
    logic [14:0] m_exp;

    function automatic logic [3:0] led_of(input logic [2:0] s, input logic f);
        case (s)
            3'd1: return 4'b0001;
            3'd2: return 4'b0010;
            3'd4: return 4'b0100;
            3'd5: return 4'b1000;
            3'd6: return {f, 1'b0, f, 1'b0};
            default: return 4'b0000;
        endcase
    endfunction

    task automatic model_reset();
        m_s = 3'd0; m_c = TAR; m_p = 0; m_f = 1'b0; m_fc = 0;
    endtask

    task automatic model_enter(input logic [2:0] ns);
        m_s = ns;
        m_p = 0;
        case (ns)
            3'd1, 3'd4: m_c = TG;
            3'd2, 3'd5: m_c = TY;
            3'd6: begin m_c = 0; m_f = 1'b1; m_fc = 0; end
            default:    m_c = TAR;
        endcase
    endtask

    task automatic model_step(input logic t, input logic k, input logic p, input logic n);
        logic [2:0] prev;
        logic       sec;
        logic       keyok;
        logic [2:0] ns;
        prev = m_s;
        if (m_s == 3'd6) begin
            if (!n) begin
                m_s = 3'd0; m_c = TAR; m_p = 0; m_f = 1'b0; m_fc = 0;
            end else if (t && !p) begin
                if (m_fc == FL - 1) begin m_fc = 0; m_f = ~m_f; end
                else m_fc++;
            end
        end else if (m_s == 3'd7) begin
            model_reset();
        end else begin
            keyok = k && !p && (m_s == 3'd0 || m_s == 3'd1 || m_s == 3'd3 || m_s == 3'd4);
            sec = 1'b0;
            if (t && !p) begin
                if (m_p == TPS - 1) begin m_p = 0; sec = 1'b1; end
                else m_p++;
            end
            if (keyok || (sec && m_c == 1)) begin
                case (m_s)
                    3'd0: ns = n ? 3'd6 : 3'd1;
                    3'd1: ns = 3'd2;
                    3'd2: ns = 3'd3;
                    3'd3: ns = n ? 3'd6 : 3'd4;
                    3'd4: ns = 3'd5;
                    default: ns = 3'd0;
                endcase
                model_enter(ns);
            end else if (sec) begin
                m_c--;
            end
        end
        m_exp = {m_s, 7'(m_c), led_of(m_s, m_f), (m_s != prev)};
    endtask

    // drive one cycle: expected result queued before the edge, outputs valid #1 after
    task automatic drive(input logic t, input logic k);
        tick_en  = t;
        key_next = k;
        model_step(t, k, pause, night_mode);
        sb.push_back(m_exp);
        @(posedge Sys_CLK);
        #1;
        tick_en  = 1'b0;
        key_next = 1'b0;
    endtask

    task automatic test_reset();
        Sys_RST = 1'b0; tick_en = 1'b0; key_next = 1'b0; pause = 1'b0; night_mode = 1'b0;
        model_reset();
        repeat (2) @(posedge Sys_CLK);
        #1;
        checks++;
        if (w_act !== {3'd0, 7'd1, 4'b0000, 1'b0}) begin
            errors++; $display("FAIL reset_state act=%h exp=%h", w_act, {3'd0, 7'd1, 4'b0000, 1'b0});
        end
        Sys_RST = 1'b1;
    endtask

    task automatic test_cycle();
        int pcs;
        pcs = 0;
        for (int i = 0; i < 48; i++) begin
            drive(1'b1, 1'b0);
            e = sb.pop_front(); checks++;
            if (w_act !== e) begin errors++; $display("FAIL cycle_seq i=%0d act=%h exp=%h", i, w_act, e); end
            if (phase_change) pcs++;
            if (i == 2) begin
                checks++;
                if (state !== 3'd0 || count !== 7'd1) begin
                    errors++; $display("FAIL cycle_allred state=%0d count=%0d exp 0/1", state, count);
                end
            end
            if (i == 3) begin
                checks++;
                if (state !== 3'd1 || count !== 7'd3 || LED !== 4'b0001) begin
                    errors++; $display("FAIL cycle_green state=%0d count=%0d LED=%b exp 1/3/0001", state, count, LED);
                end
            end
        end
        checks++;
        if (pcs != 6) begin errors++; $display("FAIL cycle_pc_pulses act=%0d exp=6", pcs); end
    endtask

    task automatic test_key();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0);
            e = sb.pop_front(); checks++;
            if (w_act !== e) begin errors++; $display("FAIL key_pre i=%0d act=%h exp=%h", i, w_act, e); end
        end
        drive(1'b0, 1'b1);
        e = sb.pop_front(); checks++;
        if (w_act !== e) begin errors++; $display("FAIL key_sb act=%h exp=%h", w_act, e); end
        checks++;
        if (state !== 3'd2 || count !== 7'd2 || phase_change !== 1'b1) begin
            errors++; $display("FAIL key_green state=%0d count=%0d pc=%b exp 2/2/1", state, count, phase_change);
        end
        drive(1'b0, 1'b1);
        e = sb.pop_front(); checks++;
        if (w_act !== e) begin errors++; $display("FAIL key_yellow_sb act=%h exp=%h", w_act, e); end
        checks++;
        if (state !== 3'd2 || count !== 7'd2 || phase_change !== 1'b0) begin
            errors++; $display("FAIL key_yellow_ignored state=%0d count=%0d pc=%b exp 2/2/0", state, count, phase_change);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0);
            e = sb.pop_front(); checks++;
            if (w_act !== e) begin errors++; $display("FAIL key_post i=%0d act=%h exp=%h", i, w_act, e); end
            if (i == 2 && count !== 7'd2) begin
                errors++; $display("FAIL key_presc_clr count=%0d exp=2", count);
            end
        end
        checks++;
        if (count !== 7'd1) begin errors++; $display("FAIL key_presc_wrap count=%0d exp=1", count); end
    endtask

    task automatic test_collide();
        for (int i = 0; i < 200 && !(m_s == 3'd4 && m_c == 1 && m_p == 3); i++) begin
            drive(1'b1, 1'b0);
            e = sb.pop_front(); checks++;
            if (w_act !== e) begin errors++; $display("FAIL collide_pre act=%h exp=%h", w_act, e); end
        end
        if (!(m_s == 3'd4 && m_c == 1 && m_p == 3)) begin errors++; $display("FAIL collide_reach timeout"); end
        drive(1'b1, 1'b1);
        e = sb.pop_front(); checks++;
        if (w_act !== e) begin errors++; $display("FAIL collide_sb act=%h exp=%h", w_act, e); end
        checks++;
        if (state !== 3'd5 || count !== 7'd2 || LED !== 4'b1000) begin
            errors++; $display("FAIL collide_single state=%0d count=%0d LED=%b exp 5/2/1000", state, count, LED);
        end
        drive(1'b0, 1'b0);
        e = sb.pop_front(); checks++;
        if (w_act !== e) begin errors++; $display("FAIL collide_hold act=%h exp=%h", w_act, e); end
    endtask

    task automatic test_pause();
        for (int i = 0; i < 200 && !(m_s == 3'd1 && m_c == 2 && m_p == 0); i++) begin
            drive(1'b1, 1'b0);
            e = sb.pop_front(); checks++;
            if (w_act !== e) begin errors++; $display("FAIL pause_pre act=%h exp=%h", w_act, e); end
        end
        if (!(m_s == 3'd1 && m_c == 2)) begin errors++; $display("FAIL pause_reach timeout"); end
        pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, (i == 5));
            e = sb.pop_front(); checks++;
            if (w_act !== e) begin errors++; $display("FAIL pause_hold i=%0d act=%h exp=%h", i, w_act, e); end
        end
        checks++;
        if (state !== 3'd1 || count !== 7'd2 || LED !== 4'b0001) begin
            errors++; $display("FAIL pause_frozen state=%0d count=%0d LED=%b exp 1/2/0001", state, count, LED);
        end
        pause = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0);
            e = sb.pop_front(); checks++;
            if (w_act !== e) begin errors++; $display("FAIL pause_resume i=%0d act=%h exp=%h", i, w_act, e); end
        end
        checks++;
        if (count !== 7'd1) begin errors++; $display("FAIL pause_release count=%0d exp=1", count); end
    endtask

    task automatic test_night();
        night_mode = 1'b1;
        for (int i = 0; i < 100 && m_s != 3'd6; i++) begin
            drive(1'b1, 1'b0);
            e = sb.pop_front(); checks++;
            if (w_act !== e) begin errors++; $display("FAIL night_pre act=%h exp=%h", w_act, e); end
        end
        if (m_s != 3'd6) begin errors++; $display("FAIL night_reach timeout"); end
        checks++;
        if (state !== 3'd6 || count !== 7'd0 || LED !== 4'b1010 || phase_change !== 1'b1) begin
            errors++; $display("FAIL night_entry state=%0d count=%0d LED=%b exp 6/0/1010", state, count, LED);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, (i == 3));
            e = sb.pop_front(); checks++;
            if (w_act !== e) begin errors++; $display("FAIL night_flash i=%0d act=%h exp=%h", i, w_act, e); end
            if (i == 1 && LED !== 4'b0000) begin errors++; $display("FAIL night_off LED=%b exp=0000", LED); end
        end
        night_mode = 1'b0;
        drive(1'b0, 1'b0);
        e = sb.pop_front(); checks++;
        if (w_act !== {3'd0, 7'd1, 4'b0000, 1'b1}) begin
            errors++; $display("FAIL night_exit act=%h exp=%h", w_act, {3'd0, 7'd1, 4'b0000, 1'b1});
        end
        night_mode = 1'b1;
        drive(1'b0, 1'b1);
        e = sb.pop_front(); checks++;
        if (w_act !== e || state !== 3'd6) begin
            errors++; $display("FAIL night_by_key act=%h exp=%h", w_act, e);
        end
        night_mode = 1'b0;
        drive(1'b0, 1'b0);
        e = sb.pop_front(); checks++;
        if (w_act !== e) begin errors++; $display("FAIL night_exit2 act=%h exp=%h", w_act, e); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 200 && !(m_s == 3'd4 && m_c == 2); i++) begin
            drive(1'b1, 1'b0);
            e = sb.pop_front(); checks++;
            if (w_act !== e) begin errors++; $display("FAIL arst_pre act=%h exp=%h", w_act, e); end
        end
        if (!(m_s == 3'd4 && m_c == 2)) begin errors++; $display("FAIL arst_reach timeout"); end
        #2 Sys_RST = 1'b0;
        #1;
        checks++;
        if (w_act !== {3'd0, 7'd1, 4'b0000, 1'b0}) begin
            errors++; $display("FAIL arst_immediate act=%h exp=%h", w_act, {3'd0, 7'd1, 4'b0000, 1'b0});
        end
        model_reset();
        @(posedge Sys_CLK);
        #1 Sys_RST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0);
            e = sb.pop_front(); checks++;
            if (w_act !== e) begin errors++; $display("FAIL arst_post i=%0d act=%h exp=%h", i, w_act, e); end
        end
    endtask

    initial begin
        test_reset();
        test_cycle();
        test_key();
        test_collide();
        test_pause();
        test_night();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
